// File: rtl/dsp_fir_mc_if.sv
// dsp_fir_mc_if: sample-in / result-out valid-ready streams of the multi-channel FIR
interface dsp_fir_mc_if #(
    parameter int DATA_WIDTH = 16,
    parameter int CH_W       = 2
);
    logic                         in_valid;
    logic                         in_ready;
    logic signed [DATA_WIDTH-1:0] in_data;
    logic [CH_W-1:0]              in_ch;
    logic                         out_valid;
    logic                         out_ready;
    logic signed [DATA_WIDTH-1:0] out_data;
    logic [CH_W-1:0]              out_ch;
    logic                         out_sat;

    modport master (
        output in_valid, in_data, in_ch, out_ready,
        input  in_ready, out_valid, out_data, out_ch, out_sat
    );

    modport slave (
        input  in_valid, in_data, in_ch, out_ready,
        output in_ready, out_valid, out_data, out_ch, out_sat
    );
endinterface

// File: rtl/dsp_fir_mc.sv
// dsp_fir_mc: time-multiplexed multi-channel FIR, one shared MAC and coefficient bank
module dsp_fir_mc #(
    parameter int DATA_WIDTH  = 16,
    parameter int COEFF_WIDTH = 16,
    parameter int TAP_COUNT   = 8,
    parameter int NUM_CH      = 4,
    parameter int ACC_WIDTH   = 40,
    parameter int OUT_SHIFT   = 15,
    parameter int CH_W        = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          clk_en,
    dsp_fir_mc_if.slave                   s,
    output logic                          ch_err,
    input  logic                          coeff_we,
    input  logic [$clog2(TAP_COUNT)-1:0]  coeff_addr,
    input  logic signed [COEFF_WIDTH-1:0] coeff_data,
    input  logic                          flush,
    output logic                          busy
);
    localparam int AW = $clog2(TAP_COUNT);
    localparam logic [CH_W:0] NCH = (CH_W + 1)'(NUM_CH);
    localparam logic [AW:0] NTAP = (AW + 1)'(TAP_COUNT);
    localparam logic [AW-1:0] LAST = AW'(TAP_COUNT - 1);
    localparam logic signed [ACC_WIDTH:0] HALF = (OUT_SHIFT == 0) ? '0 :
        (ACC_WIDTH + 1)'(1) << ((OUT_SHIFT > 0) ? OUT_SHIFT - 1 : 0);
    localparam logic signed [ACC_WIDTH:0] MAXV = {{(ACC_WIDTH - DATA_WIDTH + 2){1'b0}}, {(DATA_WIDTH - 1){1'b1}}};
    localparam logic signed [ACC_WIDTH:0] MINV = ~MAXV;

    typedef enum logic [2:0] {IDLE, SHIFT, MAC, ROUND, HOLD} state_t;

    state_t                         state;
    logic signed [DATA_WIDTH-1:0]   line [NUM_CH][TAP_COUNT];
    logic signed [COEFF_WIDTH-1:0]  coeff [TAP_COUNT];
    logic signed [DATA_WIDTH-1:0]   smp;
    logic [CH_W-1:0]                ch;
    logic [AW-1:0]                  k;
    logic signed [ACC_WIDTH-1:0]    acc;
    logic signed [ACC_WIDTH-1:0]    prod_x;
    logic signed [DATA_WIDTH+COEFF_WIDTH-1:0] prod;
    logic signed [ACC_WIDTH:0]      acc_x;
    logic signed [ACC_WIDTH:0]      r;

    assign s.in_ready = (state == IDLE);
    assign busy       = (state != IDLE);
    assign prod       = line[ch][k] * coeff[k];
    assign prod_x     = prod;
    assign acc_x      = acc;
    // round-half-up then arithmetic shift; HALF is zero when no shift is applied
    assign r          = (acc_x + HALF) >>> OUT_SHIFT;

    // control FSM, datapath and registered outputs; everything freezes when clk_en=0
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            acc         <= '0;
            k           <= '0;
            ch          <= '0;
            smp         <= '0;
            ch_err      <= 1'b0;
            s.out_valid <= 1'b0;
            s.out_data  <= '0;
            s.out_ch    <= '0;
            s.out_sat   <= 1'b0;
            for (int t = 0; t < TAP_COUNT; t++) coeff[t] <= '0;
            for (int c = 0; c < NUM_CH; c++)
                for (int t = 0; t < TAP_COUNT; t++) line[c][t] <= '0;
        end else if (clk_en) begin
            ch_err <= 1'b0;
            case (state)
                IDLE: begin
                    if (coeff_we && {1'b0, coeff_addr} < NTAP) coeff[coeff_addr] <= coeff_data;
                    if (s.in_valid) begin
                        if ({1'b0, s.in_ch} < NCH) begin
                            ch    <= s.in_ch;
                            smp   <= s.in_data;
                            state <= SHIFT;
                        end else begin
                            ch_err <= 1'b1;
                        end
                    end else if (flush) begin
                        for (int c = 0; c < NUM_CH; c++)
                            for (int t = 0; t < TAP_COUNT; t++) line[c][t] <= '0;
                    end
                end
                SHIFT: begin
                    for (int t = TAP_COUNT - 1; t > 0; t--) line[ch][t] <= line[ch][t-1];
                    line[ch][0] <= smp;
                    acc   <= '0;
                    k     <= '0;
                    state <= MAC;
                end
                MAC: begin
                    acc   <= acc + prod_x;
                    k     <= k + 1'b1;
                    state <= (k == LAST) ? ROUND : MAC;
                end
                ROUND: begin
                    s.out_data  <= (r > MAXV) ? MAXV[DATA_WIDTH-1:0] :
                                   (r < MINV) ? MINV[DATA_WIDTH-1:0] : r[DATA_WIDTH-1:0];
                    s.out_sat   <= (r > MAXV) || (r < MINV);
                    s.out_ch    <= ch;
                    s.out_valid <= 1'b1;
                    state       <= HOLD;
                end
                HOLD: begin
                    if (s.out_ready) begin
                        s.out_valid <= 1'b0;
                        state       <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_dsp_fir_mc.sv
// tb_dsp_fir_mc: three FIR instances (OUT_SHIFT 0/1/15) driven in lockstep, checked against an arithmetic model
module tb_dsp_fir_mc;
    localparam int T  = 4;
    localparam int NC = 3;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic clk_en = 1'b1;
    logic in_valid = 1'b0;
    logic signed [15:0] in_data = '0;
    logic [1:0] in_ch = '0;
    logic out_ready = 1'b1;
    logic coeff_we = 1'b0;
    logic [1:0] coeff_addr = '0;
    logic signed [15:0] coeff_data = '0;
    logic flush = 1'b0;

    logic ov [3];
    logic ir [3];
    logic os [3];
    logic ce [3];
    logic bz [3];
    logic signed [15:0] od [3];
    logic [1:0] oc [3];

    int checks = 0;
    int errors = 0;
    int line [NC][T];
    int cf [T];

    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : u
        localparam int SH = (g == 0) ? 0 : (g == 1) ? 1 : 15;
        dsp_fir_mc_if #(.DATA_WIDTH(16), .CH_W(2)) bus ();
        assign bus.in_valid  = in_valid;
        assign bus.in_data   = in_data;
        assign bus.in_ch     = in_ch;
        assign bus.out_ready = out_ready;
        assign ov[g] = bus.out_valid;
        assign ir[g] = bus.in_ready;
        assign od[g] = bus.out_data;
        assign oc[g] = bus.out_ch;
        assign os[g] = bus.out_sat;
        dsp_fir_mc #(.TAP_COUNT(T), .NUM_CH(NC), .OUT_SHIFT(SH)) dut (
            .clk(clk), .rst(rst), .clk_en(clk_en), .s(bus), .ch_err(ce[g]),
            .coeff_we(coeff_we), .coeff_addr(coeff_addr), .coeff_data(coeff_data),
            .flush(flush), .busy(bz[g])
        );
    end

    function automatic int shf(input int g);
        return (g == 0) ? 0 : (g == 1) ? 1 : 15;
    endfunction

    function automatic longint rnd(input longint a, input int s);
        return (s == 0) ? a : (a + (longint'(1) <<< (s - 1))) >>> s;
    endfunction

    task automatic chk(input string tag, input logic signed [63:0] got, input logic signed [63:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_lines();
        for (int c = 0; c < NC; c++)
            for (int t = 0; t < T; t++) line[c][t] = 0;
    endtask

    task automatic reset_chk(input string tag);
        for (int g = 0; g < 3; g++) begin
            chk($sformatf("%s_valid%0d", tag, g), ov[g], 0);
            chk($sformatf("%s_data%0d", tag, g), od[g], 0);
            chk($sformatf("%s_ch%0d", tag, g), oc[g], 0);
            chk($sformatf("%s_sat%0d", tag, g), os[g], 0);
            chk($sformatf("%s_err%0d", tag, g), ce[g], 0);
            chk($sformatf("%s_busy%0d", tag, g), bz[g], 0);
            chk($sformatf("%s_rdy%0d", tag, g), ir[g], 1);
        end
    endtask

    task automatic wcoef(input int a, input int d);
        coeff_we = 1'b1;
        coeff_addr = 2'(a);
        coeff_data = 16'(d);
        tick();
        coeff_we = 1'b0;
        cf[a] = int'(coeff_data);
    endtask

    task automatic do_flush();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        clear_lines();
    endtask

    // mode: 0 plain, 1 clk_en stall mid-MAC, 2 coeff write mid-MAC, 3 reset mid-MAC
    task automatic send(input int c, input int d, input int mode, input int hold);
        longint acc;
        longint r;
        int cnt;
        int exp_lat;
        in_ch = 2'(c);
        in_data = 16'(d);
        in_valid = 1'b1;
        out_ready = (hold == 0);
        tick();
        in_valid = 1'b0;
        chk("busy_after_accept", bz[0], 1);
        for (int t = T - 1; t > 0; t--) line[c][t] = line[c][t-1];
        line[c][0] = int'(in_data);
        acc = 0;
        for (int t = 0; t < T; t++) acc += longint'(line[c][t]) * longint'(cf[t]);
        cnt = 0;
        exp_lat = T + 2 + ((mode == 1) ? 5 : 0);
        while (!ov[0] && cnt < 60) begin
            if (cnt == 2 && mode == 1) begin
                clk_en = 1'b0;
                repeat (5) tick();
                clk_en = 1'b1;
                cnt += 5;
            end
            if (cnt == 2 && mode == 2) begin
                coeff_we = 1'b1;
                coeff_addr = 2'd0;
                coeff_data = 16'sd99;
            end
            tick();
            cnt++;
            coeff_we = 1'b0;
            if (mode == 3 && cnt == 3) begin
                rst = 1'b1;
                tick();
                rst = 1'b0;
                clear_lines();
                for (int t = 0; t < T; t++) cf[t] = 0;
                reset_chk("abort");
                return;
            end
        end
        chk("latency", cnt, exp_lat);
        for (int g = 0; g < 3; g++) begin
            r = rnd(acc, shf(g));
            chk($sformatf("valid%0d", g), ov[g], 1);
            chk($sformatf("data%0d", g), od[g], (r > 32767) ? 32767 : (r < -32768) ? -32768 : r);
            chk($sformatf("sat%0d", g), os[g], (r > 32767 || r < -32768) ? 1 : 0);
            chk($sformatf("och%0d", g), oc[g], c);
            chk($sformatf("cherr%0d", g), ce[g], 0);
        end
        if (hold > 0) begin
            r = rnd(acc, 0);
            in_valid = 1'b1;
            in_ch = 2'd1;
            in_data = 16'sd777;
            repeat (hold) begin
                tick();
                chk("hold_valid", ov[0], 1);
                chk("hold_data", od[0], (r > 32767) ? 32767 : (r < -32768) ? -32768 : r);
                chk("hold_ch", oc[0], c);
                chk("hold_ready", ir[0], 0);
            end
            in_valid = 1'b0;
            out_ready = 1'b1;
        end
        tick();
        chk("drop_valid", ov[0], 0);
        chk("ready_after_hs", ir[0], 1);
    endtask

    initial begin
        logic seen;
        clear_lines();
        for (int t = 0; t < T; t++) cf[t] = 0;
        tick();
        tick();
        rst = 1'b0;
        reset_chk("reset");

        for (int t = 0; t < T; t++) wcoef(t, t + 1);
        send(0, 100, 0, 0);
        repeat (4) send(0, 0, 0, 0);

        send(0, 100, 0, 0);
        send(1, -50, 0, 0);
        send(0, 0, 0, 0);
        send(1, 0, 0, 0);

        in_ch = 2'd3;
        in_data = 16'sd1234;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        chk("cherr_pulse", ce[0], 1);
        chk("cherr_idle", bz[0], 0);
        seen = 1'b0;
        for (int i = 0; i < T + 4; i++) begin
            tick();
            seen |= ov[0] | ce[0];
        end
        chk("cherr_once_no_out", seen, 0);

        do_flush();
        wcoef(0, 1);
        for (int t = 1; t < T; t++) wcoef(t, 0);
        send(2, 3, 0, 0);
        send(2, -3, 0, 0);
        send(2, 2, 0, 0);

        do_flush();
        for (int t = 0; t < T; t++) wcoef(t, 32'h7FFF);
        repeat (4) send(0, 32'h7FFF, 0, 0);
        repeat (4) send(1, 32'h8000, 0, 0);

        do_flush();
        wcoef(0, 5);
        send(2, 321, 0, 10);
        send(1, -7, 2, 0);
        send(0, 1000, 0, 0);
        send(2, -999, 1, 0);

        do_flush();
        send(0, 100, 0, 0);

        for (int i = 0; i < 20; i++) begin
            if ($urandom_range(0, 3) == 0) wcoef($urandom_range(0, T - 1), int'($urandom));
            if ($urandom_range(0, 7) == 0) do_flush();
            send($urandom_range(0, NC - 1), int'($urandom), 0, 0);
        end

        send(1, 555, 3, 0);
        seen = 1'b0;
        for (int i = 0; i < T + 6; i++) begin
            tick();
            seen |= ov[0];
        end
        chk("abort_no_result", seen, 0);
        send(0, 100, 0, 0);
        send(0, 0, 0, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
